// File: rtl/soc_clk_pkg.sv
// Shared types, default parameters and the counter-width helper for the
// EduSoC clock/reset block.
package soc_clk_pkg;

    typedef enum logic [1:0] {
        ST_LOCKING = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_UART_PLL_DIVIDER  = 8;
    localparam int unsigned DEF_UART_POST_DIVIDER = 4;
    localparam int unsigned DEF_LOCK_CYCLES       = 8;
    localparam int unsigned DEF_RESET_HOLD_CYCLES = 16;

    // Bits needed to hold 0..n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/soc_clk_rst_if.sv
// Status bus from the clock/reset block to the rest of the SoC.
// No handshake: every signal is a registered level, except uart_tick which is a one-cycle strobe.
interface soc_clk_rst_if;
    import soc_clk_pkg::*;

    logic       locked;
    logic       out_rst;
    logic       uart_tick;
    seq_state_t dbg_state;

    modport master (output locked, output out_rst, output uart_tick, output dbg_state);
    modport slave  (input  locked, input  out_rst, input  uart_tick, input  dbg_state);

endinterface

// File: rtl/soc_clk_divider.sv
// Modulo-N counter with enable and synchronous clear; o_wrap flags the
// enabled cycle on which the count returns from N-1 to 0.
module soc_clk_divider
    import soc_clk_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap
);

    localparam int unsigned W = cnt_width(N);
    localparam logic [W-1:0] CNT_MAX = W'(N - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max = (r_cnt == CNT_MAX);
    assign o_wrap   = i_en && w_at_max;

    // N=1 keeps the count pinned at 0, so every enabled cycle wraps.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_at_max) r_cnt <= '0;
            else          r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/soc_clk_rst.sv
// Reset sequencer (lock emulation, then reset stretch) and two-stage UART
// rate strobe generator for the EduSoC.
module soc_clk_rst
    import soc_clk_pkg::*;
#(
    parameter int unsigned UART_PLL_DIVIDER  = DEF_UART_PLL_DIVIDER,
    parameter int unsigned UART_POST_DIVIDER = DEF_UART_POST_DIVIDER,
    parameter int unsigned LOCK_CYCLES       = DEF_LOCK_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES
) (
    input  logic           clk,
    input  logic           res,
    soc_clk_rst_if.master  bus
);

    seq_state_t r_state;
    seq_state_t w_state_next;
    logic       r_locked;
    logic       r_out_rst;
    logic       r_tick;
    logic       w_locked_next;
    logic       w_out_rst_next;
    logic       w_tick_next;
    logic       w_lock_wrap;
    logic       w_hold_wrap;
    logic       w_pre_wrap;
    logic       w_post_wrap;
    logic       w_uart_clr;

    // Outside RUN the UART chain is cleared, so each release starts from phase 0.
    assign w_uart_clr = res || (r_state != ST_RUN);

    soc_clk_divider #(.N(LOCK_CYCLES)) u_lock_cnt (
        .clk    (clk),
        .i_clr  (res),
        .i_en   (r_state == ST_LOCKING),
        .o_wrap (w_lock_wrap)
    );

    soc_clk_divider #(.N(RESET_HOLD_CYCLES)) u_hold_cnt (
        .clk    (clk),
        .i_clr  (res),
        .i_en   (r_state == ST_HOLD),
        .o_wrap (w_hold_wrap)
    );

    soc_clk_divider #(.N(UART_PLL_DIVIDER)) u_pre_div (
        .clk    (clk),
        .i_clr  (w_uart_clr),
        .i_en   (r_state == ST_RUN),
        .o_wrap (w_pre_wrap)
    );

    soc_clk_divider #(.N(UART_POST_DIVIDER)) u_post_div (
        .clk    (clk),
        .i_clr  (w_uart_clr),
        .i_en   (w_pre_wrap),
        .o_wrap (w_post_wrap)
    );

    always_comb begin
        w_state_next   = r_state;
        w_locked_next  = r_locked;
        w_out_rst_next = r_out_rst;
        w_tick_next    = 1'b0;
        unique case (r_state)
            ST_LOCKING: begin
                if (w_lock_wrap) begin
                    w_state_next  = ST_HOLD;
                    w_locked_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_hold_wrap) begin
                    w_state_next   = ST_RUN;
                    w_out_rst_next = 1'b0;
                end
            end
            ST_RUN: begin
                // Post stage only wraps while the pre stage wraps: both at max.
                w_tick_next = w_post_wrap;
            end
            default: begin
                w_state_next = ST_LOCKING;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state   <= ST_LOCKING;
            r_locked  <= 1'b0;
            r_out_rst <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_locked  <= w_locked_next;
            r_out_rst <= w_out_rst_next;
            r_tick    <= w_tick_next;
        end
    end

    assign bus.locked    = r_locked;
    assign bus.out_rst   = r_out_rst;
    assign bus.uart_tick = r_tick;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_soc_clk_rst.sv
// Bench for soc_clk_rst: three parameterisations share one reset stimulus and
// are checked every cycle against a cycles-since-release model.
module tb_soc_clk_rst;
    import soc_clk_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   k_rel  = 0;

    always #5 clk = ~clk;

    soc_clk_rst_if bus_d ();
    soc_clk_rst_if bus_o ();
    soc_clk_rst_if bus_f ();

    soc_clk_rst #(
        .UART_PLL_DIVIDER (8), .UART_POST_DIVIDER (4),
        .LOCK_CYCLES      (8), .RESET_HOLD_CYCLES (16)
    ) dut_d (.clk(clk), .res(res), .bus(bus_d));

    soc_clk_rst #(
        .UART_PLL_DIVIDER (1), .UART_POST_DIVIDER (1),
        .LOCK_CYCLES      (1), .RESET_HOLD_CYCLES (1)
    ) dut_o (.clk(clk), .res(res), .bus(bus_o));

    soc_clk_rst #(
        .UART_PLL_DIVIDER (3), .UART_POST_DIVIDER (5),
        .LOCK_CYCLES      (8), .RESET_HOLD_CYCLES (16)
    ) dut_f (.clk(clk), .res(res), .bus(bus_f));

    // Reference: number of consecutive edges that sampled res=0.
    always @(posedge clk) begin
        if (res) k_rel <= 0;
        else     k_rel <= k_rel + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {locked, out_rst, uart_tick} k edges after release.
    function automatic logic [2:0] model(input int k, input int p, input int q, input int l, input int h);
        logic lk, rs, tk;
        lk = (k >= l);
        rs = (k < l + h);
        tk = (k > l + h) && (((k - l - h) % (p * q)) == 0);
        return {lk, rs, tk};
    endfunction

    function automatic seq_state_t model_state(input int k, input int l, input int h);
        if (k < l)     return ST_LOCKING;
        if (k < l + h) return ST_HOLD;
        return ST_RUN;
    endfunction

    always @(negedge clk) begin
        logic [2:0] e;
        e = model(k_rel, 8, 4, 8, 16);
        check("d_locked", bus_d.locked, e[2]);
        check("d_out_rst", bus_d.out_rst, e[1]);
        check("d_uart_tick", bus_d.uart_tick, e[0]);
        check("d_state", bus_d.dbg_state, model_state(k_rel, 8, 16));
        e = model(k_rel, 1, 1, 1, 1);
        check("o_locked", bus_o.locked, e[2]);
        check("o_out_rst", bus_o.out_rst, e[1]);
        check("o_uart_tick", bus_o.uart_tick, e[0]);
        check("o_state", bus_o.dbg_state, model_state(k_rel, 1, 1));
        e = model(k_rel, 3, 5, 8, 16);
        check("f_locked", bus_f.locked, e[2]);
        check("f_out_rst", bus_f.out_rst, e[1]);
        check("f_uart_tick", bus_f.uart_tick, e[0]);
        check("f_state", bus_f.dbg_state, model_state(k_rel, 8, 16));
    end

    // Walks ncyc cycles after a release and records first-event cycle numbers.
    task automatic measure(input int ncyc, output int t_lock, output int t_rst, output int t_tick,
                           output int n_tick, output int o_rst, output int o_tick);
        t_lock = -1; t_rst = -1; t_tick = -1; n_tick = 0; o_rst = -1; o_tick = -1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (t_lock < 0 && bus_d.locked === 1'b1)    t_lock = k;
            if (t_rst < 0 && bus_d.out_rst === 1'b0)    t_rst = k;
            if (t_tick < 0 && bus_d.uart_tick === 1'b1) t_tick = k;
            if (bus_d.uart_tick === 1'b1)               n_tick++;
            if (o_rst < 0 && bus_o.out_rst === 1'b0)    o_rst = k;
            if (o_tick < 0 && bus_o.uart_tick === 1'b1) o_tick = k;
        end
    endtask

    initial begin
        int t_lock, t_rst, t_tick, n_tick, o_rst, o_tick;
        int f_last, f_cnt;

        res = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_locked", bus_d.locked, 1'b0);
        check("rst_out_rst", bus_d.out_rst, 1'b1);
        check("rst_uart_tick", bus_d.uart_tick, 1'b0);

        // Plain release: lock at 8, reset drop at 24, ticks from 56 every 32.
        res = 1'b0;
        measure(400, t_lock, t_rst, t_tick, n_tick, o_rst, o_tick);
        check("lit_lock_cycle", t_lock, 8);
        check("lit_rst_cycle", t_rst, 24);
        check("lit_first_tick", t_tick, 56);
        check("lit_tick_count", n_tick, 11);
        check("lit_ones_rst", o_rst, 2);
        check("lit_ones_tick", o_tick, 3);

        // One-cycle reset pulse in the middle of HOLD.
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        repeat (11) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("hold_pulse_locked", bus_d.locked, 1'b0);
        check("hold_pulse_out_rst", bus_d.out_rst, 1'b1);
        res = 1'b0;
        measure(100, t_lock, t_rst, t_tick, n_tick, o_rst, o_tick);
        check("restart_lock", t_lock, 8);
        check("restart_rst", t_rst, 24);
        check("restart_tick", t_tick, 56);

        // Reset in RUN between ticks, then no leftover phase.
        res = 1'b1;
        repeat (2) @(negedge clk);
        check("run_rst_tick", bus_d.uart_tick, 1'b0);
        res = 1'b0;
        measure(100, t_lock, t_rst, t_tick, n_tick, o_rst, o_tick);
        check("run_restart_tick", t_tick, 56);

        // Random reset pulses at random points in the sequence.
        for (int i = 0; i < 25; i++) begin
            res = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            res = 1'b0;
            repeat ($urandom_range(1, 90)) @(negedge clk);
        end

        // Long run for the 3x5 divider: period exactly 15.
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        f_last = -1;
        f_cnt  = 0;
        for (int k = 1; k <= 1800; k++) begin
            @(negedge clk);
            if (bus_f.uart_tick === 1'b1) begin
                if (f_last < 0) check("f_first_tick", k, 39);
                else            check("f_period", k - f_last, 15);
                f_last = k;
                f_cnt++;
            end
        end
        check("f_tick_count", f_cnt, 118);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
